dmx_rx: RTL and testbench

DMX512 receiver: decodes an incoming 250 kbaud DMX512 serial line (break, mark-after-break, 8N2 slots) into a 513-entry slot buffer. Slot 0 holds the start code and slots 1..512 hold channel data. The buffer is readable by the ece453 register front-end through a synchronous read port. The block is the receive-side counterpart of the existing DMX transmitter, sitting beside it under ece453 with its serial input driven from a gpio_inputs pin.

---
 rtl/dmx_pkg.sv | 14 +
 rtl/dmx_rx_sync.sv | 16 +
 rtl/dmx_rx.sv | 171 +++++++++++++++++
 tb/tb_dmx_rx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmx_pkg.sv
// dmx_pkg: shared DMX512 definitions (slot count, slot index type, receiver FSM states, timing helpers).
package dmx_pkg;
    localparam int DMX_SLOTS = 513;
    typedef logic [9:0] slot_idx_t;
    typedef enum logic [2:0] {
        IDLE, BREAK, MAB, WAIT_START, START, DATA, STOP, STOP_LOW
    } dmx_state_e;
    function automatic int bit_cycles(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction
    function automatic int us_cycles(input int clk_hz, input int us);
        return clk_hz / 1_000_000 * us;
    endfunction
endpackage

// File: rtl/dmx_rx_sync.sv
// dmx_rx_sync: 2-flop synchronizer for the raw DMX line plus a one-cycle falling-edge flag.
module dmx_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o,
    output logic fall_o
);
    logic [2:0] ff_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ff_q <= '1;
        else        ff_q <= {ff_q[1:0], d_i};
    end
    assign q_o    = ff_q[1];
    assign fall_o = ff_q[2] & ~ff_q[1];
endmodule

// File: rtl/dmx_rx.sv
// dmx_rx: DMX512 receiver decoding break/MAB/8N2 slots into a 513-entry slot buffer with a registered read port.
// Define DMX_RX_NULL_SC_ONLY_EN to ignore frames whose start code is not 8'h00.
module dmx_rx
    import dmx_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BAUD     = 250_000,
    parameter int BREAK_US = 88,
    parameter int MAB_US   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dmx_in,
    input  logic [9:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       frame_done,
    output logic [9:0] slot_count,
    output logic [7:0] start_code,
    output logic       framing_err,
    output logic       in_frame
);
    localparam int CW = 24;
    localparam int BIT_CYC   = bit_cycles(CLK_HZ, BAUD);
    localparam int BREAK_CYC = us_cycles(CLK_HZ, BREAK_US);
    localparam int MAB_CYC   = us_cycles(CLK_HZ, MAB_US);
    localparam logic [CW-1:0] BIT_C   = BIT_CYC[CW-1:0];
    localparam logic [CW-1:0] HALF_C  = BIT_C >> 1;
    localparam logic [CW-1:0] BREAK_C = BREAK_CYC[CW-1:0];
    localparam logic [CW-1:0] MAB_C   = MAB_CYC[CW-1:0];

    logic rx, fall, we, end_frame, reject;
    dmx_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, smp_q, smp_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d, cur_sc_q, cur_sc_d, start_code_q, start_code_d, rd_data_q;
    slot_idx_t slot_q, slot_d, slot_count_q, slot_count_d;
    logic in_frame_q, in_frame_d, frame_done_q, frame_done_d, framing_err_q, framing_err_d;
    logic [7:0] mem [DMX_SLOTS];

    dmx_rx_sync u_sync (.clk(clk), .reset(reset), .d_i(dmx_in), .q_o(rx), .fall_o(fall));

`ifdef DMX_RX_NULL_SC_ONLY_EN
    assign reject = (slot_q == '0) && (sh_q != 8'h00);
`else
    assign reject = 1'b0;
`endif

    // cnt_q runs continuously from the start edge so a low stop bit can grow into a break
    always_comb begin
        state_d       = state_q;
        cnt_d         = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
        smp_d         = smp_q;
        bit_d         = bit_q;
        sh_d          = sh_q;
        slot_d        = slot_q;
        cur_sc_d      = cur_sc_q;
        in_frame_d    = in_frame_q;
        slot_count_d  = slot_count_q;
        start_code_d  = start_code_q;
        frame_done_d  = 1'b0;
        framing_err_d = 1'b0;
        we            = 1'b0;
        end_frame     = 1'b0;
        case (state_q)
            IDLE: if (!rx) begin
                cnt_d   = '0;
                state_d = BREAK;
            end
            BREAK: if (rx) begin
                cnt_d   = '0;
                state_d = (cnt_q >= BREAK_C) ? MAB : IDLE;
            end
            MAB: if (!rx) begin
                cnt_d      = '0;
                smp_d      = HALF_C;
                slot_d     = (cnt_q >= MAB_C) ? '0 : slot_q;
                in_frame_d = (cnt_q >= MAB_C) | in_frame_q;
                state_d    = (cnt_q >= MAB_C) ? START : BREAK;
            end
            WAIT_START: if (fall) begin
                cnt_d   = '0;
                smp_d   = HALF_C;
                state_d = START;
            end
            START: if (cnt_q == smp_q) begin
                smp_d   = smp_q + BIT_C;
                bit_d   = '0;
                state_d = rx ? WAIT_START : DATA;
            end
            DATA: if (cnt_q == smp_q) begin
                smp_d   = smp_q + BIT_C;
                sh_d    = {rx, sh_q[7:1]};
                bit_d   = bit_q + 3'd1;
                state_d = (bit_q == 3'd7) ? STOP : DATA;
            end
            STOP: if (cnt_q == smp_q) begin
                if (!rx) begin
                    state_d = STOP_LOW;
                end else if (reject) begin
                    in_frame_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    we        = 1'b1;
                    slot_d    = slot_q + 10'd1;
                    cur_sc_d  = (slot_q == '0) ? sh_q : cur_sc_q;
                    end_frame = (slot_q == 10'(DMX_SLOTS - 1));
                    state_d   = end_frame ? IDLE : WAIT_START;
                end
            end
            STOP_LOW: if (rx) begin
                framing_err_d = 1'b1;
                in_frame_d    = 1'b0;
                state_d       = IDLE;
            end else if (cnt_q >= BREAK_C) begin
                in_frame_d = 1'b0;
                end_frame  = (slot_q != '0);
                state_d    = BREAK;
            end
            default: state_d = IDLE;
        endcase
        if (end_frame) begin
            frame_done_d = 1'b1;
            in_frame_d   = 1'b0;
            slot_count_d = slot_d;
            start_code_d = cur_sc_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            smp_q         <= '0;
            bit_q         <= '0;
            sh_q          <= '0;
            slot_q        <= '0;
            cur_sc_q      <= '0;
            in_frame_q    <= 1'b0;
            slot_count_q  <= '0;
            start_code_q  <= '0;
            frame_done_q  <= 1'b0;
            framing_err_q <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            smp_q         <= smp_d;
            bit_q         <= bit_d;
            sh_q          <= sh_d;
            slot_q        <= slot_d;
            cur_sc_q      <= cur_sc_d;
            in_frame_q    <= in_frame_d;
            slot_count_q  <= slot_count_d;
            start_code_q  <= start_code_d;
            frame_done_q  <= frame_done_d;
            framing_err_q <= framing_err_d;
            rd_data_q     <= (rd_addr > 10'd512) ? 8'h00 : mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[slot_q] <= sh_q;
    end

    assign rd_data     = rd_data_q;
    assign frame_done  = frame_done_q;
    assign slot_count  = slot_count_q;
    assign start_code  = start_code_q;
    assign framing_err = framing_err_q;
    assign in_frame    = in_frame_q;
endmodule

// File: tb/tb_dmx_rx.sv
// tb_dmx_rx: scoreboard bench for dmx_rx at CLK_HZ = 1 MHz (4 cycles per bit, 1 cycle per microsecond).
module tb_dmx_rx;
    typedef struct {
        logic [9:0] cnt;
        logic [7:0] sc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       dmx_in = 1'b1;
    logic [9:0] rd_addr = '0;
    logic [7:0] rd_data, start_code;
    logic [9:0] slot_count;
    logic       frame_done, framing_err, in_frame;

    int vectors = 0, errors = 0, done_cnt = 0, err_cnt = 0;
    bit inf_seen = 1'b0;
    logic [7:0] exp_mem [513];
    logic [7:0] last_sc = 8'h00;
    logic [7:0] fb [$];
    exp_t sb [$];

    always #5 clk = ~clk;

    dmx_rx #(.CLK_HZ(1_000_000)) dut (
        .clk(clk), .reset(reset), .dmx_in(dmx_in), .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_done(frame_done), .slot_count(slot_count), .start_code(start_code),
        .framing_err(framing_err), .in_frame(in_frame)
    );

    always @(negedge clk) begin
        if (in_frame) inf_seen = 1'b1;
        if (framing_err) err_cnt++;
        if (frame_done && framing_err) begin
            errors++;
            $display("FAIL pulse_overlap frame_done=1 framing_err=1 required not both");
        end
        if (frame_done) begin
            done_cnt++;
            vectors++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame slot_count=%0d start_code=%h required no frame", slot_count, start_code);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (slot_count !== e.cnt || start_code !== e.sc) begin
                    errors++;
                    $display("FAIL frame_result slot_count=%0d start_code=%h required %0d %h", slot_count, start_code, e.cnt, e.sc);
                end
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog run exceeded 60000 cycles required completion");
        $fatal(1, "timeout");
    end

    task automatic line(input logic v, input int n);
        dmx_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        line(1'b0, 4);
        for (int i = 0; i < 8; i++) line(b[i], 4);
        line(1'b1, 8);
    endtask

    task automatic send_frame(input bit push);
        bit rej;
        rej = 1'b0;
`ifdef DMX_RX_NULL_SC_ONLY_EN
        rej = (fb[0] != 8'h00);
`endif
        if (push && !rej) sb.push_back('{10'(fb.size()), fb[0]});
        line(1'b0, 100);
        line(1'b1, 12);
        foreach (fb[i]) begin
            send_byte(fb[i]);
            if (!rej) exp_mem[i] = fb[i];
        end
    endtask

    task automatic end_break();
        line(1'b0, 100);
        line(1'b1, 20);
    endtask

    task automatic do_read(input logic [9:0] a, input logic [7:0] exp, input string name);
        rd_addr = a;
        @(posedge clk);
        #1;
        vectors++;
        if (rd_data !== exp) begin
            errors++;
            $display("FAIL %s rd_data=%h required %h (addr %0d)", name, rd_data, exp, a);
        end
    endtask

    task automatic check_count(input int got, input int exp, input string name);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s count=%0d required %0d", name, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        vectors++;
        if ({rd_data, frame_done, slot_count, start_code, framing_err, in_frame} !== 29'd0) begin
            errors++;
            $display("FAIL %s rd=%h fd=%b cnt=%0d sc=%h fe=%b if=%b required all zero",
                     name, rd_data, frame_done, slot_count, start_code, framing_err, in_frame);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_values");
        reset = 1'b1;
        line(1'b1, 10);
    endtask

    task automatic test_short_frame();
        int d0;
        fb = '{8'h00, 8'h11, 8'h22, 8'h33};
        d0 = done_cnt;
        send_frame(1'b1);
        end_break();
        check_count(done_cnt, d0 + 1, "short_frame_done");
        do_read(10'd2, 8'h22, "short_frame_slot2");
        do_read(10'd3, exp_mem[3], "short_frame_slot3");
    endtask

    task automatic test_full_frame();
        int d0;
        fb.delete();
        for (int i = 0; i < 513; i++) fb.push_back(i[7:0]);
        d0 = done_cnt;
        send_frame(1'b1);
        check_count(done_cnt, d0 + 1, "full_frame_done_after_last_stop");
        line(1'b1, 5);
        do_read(10'd512, 8'h00, "full_slot512");
        do_read(10'd600, 8'h00, "full_addr600");
        do_read(10'd300, 8'h2C, "full_slot300");
        do_read(10'd255, 8'hFF, "full_slot255");
    endtask

    task automatic test_short_break();
        int d0;
        d0 = done_cnt;
        inf_seen = 1'b0;
        line(1'b0, 50);
        line(1'b1, 20);
        check_count(int'(inf_seen), 0, "short_break_in_frame");
        check_count(done_cnt, d0, "short_break_no_frame");
        fb = '{8'h00, 8'h5A, 8'hA5};
        send_frame(1'b1);
        end_break();
        check_count(done_cnt, d0 + 1, "after_short_break_done");
        do_read(10'd1, 8'h5A, "after_short_break_slot1");
        do_read(10'd2, 8'hA5, "after_short_break_slot2");
    endtask

    task automatic test_framing();
        int d0, e0;
        logic [7:0] b;
        b = 8'h3C;
        fb = '{8'h00, 8'h77};
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(1'b0);
        check_count(int'(in_frame), 1, "framing_in_frame_before");
        line(1'b0, 4);
        for (int i = 0; i < 8; i++) line(b[i], 4);
        line(1'b0, 4);
        line(1'b1, 20);
        check_count(err_cnt, e0 + 1, "framing_err_pulse");
        check_count(done_cnt, d0, "framing_no_done");
        check_count(int'(in_frame), 0, "framing_in_frame_after");
        fb = '{8'h00, 8'h44};
        send_frame(1'b1);
        end_break();
        check_count(done_cnt, d0 + 1, "after_framing_done");
        do_read(10'd1, 8'h44, "after_framing_slot1");
    endtask

    task automatic test_null_sc();
        int d0;
        fb = '{8'hCC, 8'h99};
        d0 = done_cnt;
        send_frame(1'b1);
        end_break();
`ifdef DMX_RX_NULL_SC_ONLY_EN
        check_count(done_cnt, d0, "null_sc_no_done");
`else
        last_sc = 8'hCC;
        check_count(done_cnt, d0 + 1, "any_sc_done");
`endif
        vectors++;
        if (start_code !== last_sc) begin
            errors++;
            $display("FAIL start_code_out start_code=%h required %h", start_code, last_sc);
        end
        do_read(10'd1, exp_mem[1], "null_sc_slot1");
    endtask

    task automatic test_reset_mid();
        fb = '{8'h00, 8'h12, 8'h34};
        send_frame(1'b0);
        line(1'b0, 4);
        line(1'b1, 4);
        line(1'b0, 4);
        reset = 1'b0;
        #1;
        check_reset_outputs("reset_mid_frame");
        repeat (3) @(posedge clk);
        #1;
        dmx_in = 1'b1;
        reset = 1'b1;
        line(1'b1, 10);
        fb = '{8'h00, 8'hAB, 8'hCD};
        send_frame(1'b1);
        end_break();
        do_read(10'd2, 8'hCD, "after_reset_slot2");
        do_read(10'd1, 8'hAB, "after_reset_slot1");
    endtask

    initial begin
        test_reset();
        test_short_frame();
        test_full_frame();
        test_short_break();
        test_framing();
        test_null_sc();
        test_reset_mid();
        check_count(sb.size(), 0, "scoreboard_drained");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
